// File: rtl/grid_matrix_scanner.sv
// grid_matrix_scanner: drives a row-multiplexed LED matrix from the flat game grid.
// Grid updates land in a shadow buffer and are promoted to the displayed buffer
// only at frame boundaries, so a frame never tears. Each row is preceded by an
// all-off blanking gap.
// Optional cursor overlay: define GRID_SCAN_CURSOR_EN.
//
// Handshake: grid_valid is a single-cycle strobe with no ready; the scanner
// always accepts, and the last strobe before a frame boundary wins.
//
// Timing: the first clock edge after reset release enters the first frame, so
// frame_start is high in the first full clock period after release.
module grid_matrix_scanner #(
    parameter int GRID_W       = 7,
    parameter int GRID_H       = 7,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter int CURSOR_BLINK = 8
) (
    input  logic                                       clka,
    input  logic                                       rst_n,
    input  logic [GRID_W*GRID_H-1:0]                   grid,
    input  logic                                       grid_valid,
`ifdef GRID_SCAN_CURSOR_EN
    input  logic                                       cursor_en,
    input  logic [(GRID_H > 1 ? $clog2(GRID_H) : 1)-1:0] cursor_row,
    input  logic [(GRID_W > 1 ? $clog2(GRID_W) : 1)-1:0] cursor_col,
`endif
    output logic [GRID_H-1:0]                          row_sel,
    output logic [GRID_W-1:0]                          col_data,
    output logic                                       frame_start,
    output logic                                       dbg_state
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int ROW_W   = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(GRID_H - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // With no blanking the row cycle is ON->ON, so row 0 starts directly in ON.
    localparam state_t FIRST_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

    state_t               state_q, nxt_state;
    logic [ROW_W-1:0]     row_q, nxt_row;
    logic [CNT_W-1:0]     cnt_q, nxt_cnt;
    logic                 started_q;
    logic [N_CELLS-1:0]   shadow_q, active_q, nxt_active;
    logic                 pending_q, nxt_pending;
    logic                 wrap, at_bnd;
    logic [GRID_W-1:0]    row_bits, nxt_col;
    logic [GRID_H-1:0]    nxt_sel;

`ifdef GRID_SCAN_CURSOR_EN
    localparam int BLINK_W = (CURSOR_BLINK > 1) ? $clog2(CURSOR_BLINK + 1) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(CURSOR_BLINK - 1);
    logic [BLINK_W-1:0]   blink_cnt_q, nxt_blink_cnt;
    logic                 blink_q, nxt_blink;
    logic [GRID_W-1:0]    cursor_mask;
`endif

    assign dbg_state = state_q;

    // Next-state: row/dwell sequencing, buffer promotion and the next output image.
    always_comb begin
        nxt_state   = state_q;
        nxt_row     = row_q;
        nxt_cnt     = cnt_q;
        wrap        = 1'b0;
        nxt_active  = active_q;
        nxt_pending = pending_q;
        row_bits    = '0;
        nxt_col     = '0;
        nxt_sel     = '0;

        at_bnd = started_q && (state_q == FIRST_STATE) && (row_q == '0) && (cnt_q == '0);

        if (!started_q) begin
            // Leaving reset: enter the first frame boundary.
            nxt_state = FIRST_STATE;
            nxt_row   = '0;
            nxt_cnt   = '0;
            wrap      = 1'b1;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                nxt_state = ST_ON;
                nxt_cnt   = '0;
            end else begin
                nxt_cnt = cnt_q + CNT_W'(1);
            end
        end else begin
            if (cnt_q == DWELL_LAST) begin
                nxt_state = FIRST_STATE;
                nxt_cnt   = '0;
                if (row_q == ROW_LAST) begin
                    nxt_row = '0;
                    wrap    = 1'b1;
                end else begin
                    nxt_row = row_q + ROW_W'(1);
                end
            end else begin
                nxt_cnt = cnt_q + CNT_W'(1);
            end
        end

        if (wrap) begin
            // A strobe on the last cycle of a frame is newer than anything pending.
            nxt_active  = grid_valid ? grid : (pending_q ? shadow_q : active_q);
            nxt_pending = 1'b0;
        end else if (at_bnd && grid_valid) begin
            nxt_active  = grid;
            nxt_pending = 1'b0;
        end else if (grid_valid) begin
            nxt_pending = 1'b1;
        end

        row_bits = nxt_active[int'(nxt_row) * GRID_W +: GRID_W];

        if (nxt_state == ST_ON) begin
            nxt_col = row_bits;
            for (int r = 0; r < GRID_H; r++) begin
                nxt_sel[r] = (int'(nxt_row) == r);
            end
        end
    end

`ifdef GRID_SCAN_CURSOR_EN
    // Cursor overlay: blink phase advances on frame starts after the first one.
    always_comb begin
        nxt_blink_cnt = blink_cnt_q;
        nxt_blink     = blink_q;
        cursor_mask   = '0;
        if (wrap && started_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                nxt_blink_cnt = '0;
                nxt_blink     = ~blink_q;
            end else begin
                nxt_blink_cnt = blink_cnt_q + BLINK_W'(1);
            end
        end
        if (cursor_en && (nxt_state == ST_ON) && (int'(cursor_row) == int'(nxt_row))) begin
            for (int c = 0; c < GRID_W; c++) begin
                cursor_mask[c] = (int'(cursor_col) == c) && nxt_blink;
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= nxt_blink_cnt;
            blink_q     <= nxt_blink;
        end
    end
`endif

    // Scan FSM, frame buffers and registered matrix drive.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            row_q       <= '0;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            row_q       <= nxt_row;
            cnt_q       <= nxt_cnt;
            started_q   <= 1'b1;
            if (grid_valid) begin
                shadow_q <= grid;
            end
            active_q    <= nxt_active;
            pending_q   <= nxt_pending;
            row_sel     <= nxt_sel;
`ifdef GRID_SCAN_CURSOR_EN
            col_data    <= nxt_col ^ cursor_mask;
`else
            col_data    <= nxt_col;
`endif
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_grid_matrix_scanner.sv
// tb_grid_matrix_scanner: directed frames then randomized grid strobes and a
// mid-frame reset, checked against a frame-level model of the display.
module tb_grid_matrix_scanner;

    localparam int W     = 7;
    localparam int H     = 7;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = H * SLOT;
    localparam int BLINK = 1;
    localparam int N     = W * H;
`ifdef GRID_SCAN_CURSOR_EN
    localparam bit CURSOR_ON = 1'b1;
`else
    localparam bit CURSOR_ON = 1'b0;
`endif

    logic          clka = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  grid = '0;
    logic          grid_valid = 1'b0;
    logic          cursor_en = 1'b1;
    logic [2:0]    cursor_row = 3'd2;
    logic [2:0]    cursor_col = 3'd5;
    logic [H-1:0]  row_sel;
    logic [W-1:0]  col_data;
    logic          frame_start;
    logic          dbg_state;

    grid_matrix_scanner #(
        .GRID_W(W), .GRID_H(H), .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK), .CURSOR_BLINK(BLINK)
    ) dut (
        .clka(clka), .rst_n(rst_n), .grid(grid), .grid_valid(grid_valid),
`ifdef GRID_SCAN_CURSOR_EN
        .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
`endif
        .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    // Model: cycle index since reset release, newest strobed grid, grid shown this frame.
    int           n = 0;
    logic [N-1:0] last_grid = '0;
    logic [N-1:0] frame_grid = '0;
    logic [15:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h exp %0h", tag, n, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict the display, then check mid-cycle.
    task automatic step(input logic gv, input logic [N-1:0] g);
        int t, k, slot, off;
        logic [H-1:0] e_sel;
        logic [W-1:0] e_col;
        logic         e_fs;
        logic [15:0]  e;
        @(posedge clka);
        #1;
        grid_valid = gv;
        grid       = g;
        t    = n % FRAME;
        k    = n / FRAME;
        slot = t / SLOT;
        off  = t % SLOT;
        if (gv) last_grid = g;
        if (t == 0) frame_grid = last_grid;
        e_fs  = (t == 0);
        e_sel = '0;
        e_col = '0;
        if (off >= BLANK) begin
            e_sel[slot] = 1'b1;
            e_col = frame_grid[slot*W +: W];
            if (CURSOR_ON && cursor_en && (int'(cursor_row) == slot) && (int'(cursor_col) < W)
                && ((k / BLINK) % 2 == 1)) begin
                e_col[cursor_col] = ~e_col[cursor_col];
            end
        end
        exp_q.push_back({e_fs, 1'b0, e_sel, e_col});
        @(negedge clka);
        e = exp_q.pop_front();
        check_eq("frame_start", 64'(frame_start), 64'(e[15]));
        check_eq("row_sel", 64'(row_sel), 64'(e[13:7]));
        check_eq("col_data", 64'(col_data), 64'(e[6:0]));
        n++;
    endtask

    task automatic reset_model();
        n          = 0;
        last_grid  = '0;
        frame_grid = '0;
    endtask

    function automatic logic [N-1:0] rand_grid();
        logic [63:0] tmp;
        tmp = {$urandom(), $urandom()};
        return tmp[N-1:0];
    endfunction

    initial begin
        logic [N-1:0] checker_grid;
        logic [N-1:0] g;
        logic         gv;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                checker_grid[r*W + c] = ((r + c) % 2 == 0);

        // Reset held over several edges: outputs must stay cleared.
        repeat (3) @(posedge clka);
        @(negedge clka);
        check_eq("rst_row_sel", 64'(row_sel), 64'd0);
        check_eq("rst_col_data", 64'(col_data), 64'd0);
        check_eq("rst_frame_start", 64'(frame_start), 64'd0);
        rst_n = 1'b1;
        reset_model();

        // Directed frames 0..3: single cell, back-to-back strobes, boundary bypass.
        for (int i = 0; i < 4 * FRAME; i++) begin
            gv = 1'b0;
            g  = '0;
            if (n == 10) begin gv = 1'b1; g = '0; g[0] = 1'b1; end
            if (n == FRAME + 5) begin gv = 1'b1; g = '0; g[6*W + 6] = 1'b1; end
            if (n == FRAME + 6) begin gv = 1'b1; g = '0; g[3*W + 2] = 1'b1; end
            if (n == 3 * FRAME) begin gv = 1'b1; g = checker_grid; end
            step(gv, g);
        end

        // Random strobes; cursor reprogrammed only at frame starts.
        for (int i = 0; i < 14 * FRAME; i++) begin
            if (n % FRAME == 0) begin
                cursor_en  = 1'($urandom_range(0, 3) != 0);
                cursor_row = 3'($urandom_range(0, 7));
                cursor_col = 3'($urandom_range(0, 7));
            end
            gv = ($urandom_range(0, 7) == 0);
            if (n % FRAME == FRAME - 1 || n % FRAME == 0) gv = ($urandom_range(0, 1) == 0);
            step(gv, rand_grid());
        end

        // Advance to the middle of row 3, then pulse reset for one cycle.
        while (n % FRAME != 20) step(1'b0, '0);
        step(1'b1, rand_grid());
        #2;
        grid_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_eq("midrst_row_sel", 64'(row_sel), 64'd0);
        check_eq("midrst_col_data", 64'(col_data), 64'd0);
        check_eq("midrst_frame_start", 64'(frame_start), 64'd0);
        @(negedge clka);
        rst_n = 1'b1;
        reset_model();

        // After reset: the pending strobe is gone, frames restart cleanly.
        for (int i = 0; i < 4 * FRAME; i++) begin
            gv = ($urandom_range(0, 9) == 0);
            step(gv, rand_grid());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
